// File: rtl/output_pipe_pkg.sv
// Shared types and widths for the output pipeline's divider path.
package output_pipe_pkg;

  localparam int unsigned DIVIDEND_W = 28;
  localparam int unsigned DIVISOR_W  = 20;
  localparam int unsigned QUOT_W     = 8;
  localparam int unsigned CHAN_W     = 3;

  localparam logic [QUOT_W-1:0] DIV0_RESULT = 8'hFF;

  typedef struct packed {
    logic              valid;
    logic [CHAN_W-1:0] chan;
    logic              z;
  } div_tag_t;

endpackage

// File: rtl/output_div_scheduler_if.sv
// Requester, divider and result signals of the shared divider scheduler.
interface output_div_scheduler_if
  import output_pipe_pkg::*;
#(
  parameter int unsigned NUM_CH = 4
) ();

  logic [NUM_CH-1:0]            req;
  logic [NUM_CH*DIVIDEND_W-1:0] req_data;
  logic [NUM_CH*DIVISOR_W-1:0]  req_divisor;
  logic [NUM_CH-1:0]            ack;
  logic                         ready;
  logic                         div_start;
  logic [DIVIDEND_W-1:0]        div_dividend;
  logic [DIVISOR_W-1:0]         div_divisor;
  logic                         div_startout;
  logic [QUOT_W-1:0]            div_q;
  logic                         res_valid;
  logic [CHAN_W-1:0]            res_chan;
  logic [QUOT_W-1:0]            res_data;
  logic                         err;

  // Scheduler side.
  modport master (
    input  req, req_data, req_divisor, div_startout, div_q,
    output ack, ready, div_start, div_dividend, div_divisor, res_valid, res_chan, res_data, err
  );

  // Requesters, divider and result consumer side.
  modport slave (
    output req, req_data, req_divisor, div_startout, div_q,
    input  ack, ready, div_start, div_dividend, div_divisor, res_valid, res_chan, res_data, err
  );

endinterface

// File: rtl/div_tag_pipe.sv
// Delay line of issue tags, matched to the divider pipeline depth.
module div_tag_pipe
  import output_pipe_pkg::*;
#(
  parameter int unsigned Depth = 10
) (
  input  logic     clock,
  input  logic     reset,
  input  div_tag_t tag_in,
  output div_tag_t tag_out
);

  div_tag_t [Depth-1:0] stage_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stage_q <= '0;
    end else begin
      stage_q[0] <= tag_in;
      for (int unsigned i = 1; i < Depth; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign tag_out = stage_q[Depth-1];

endmodule

// File: rtl/output_div_scheduler.sv
// Round-robin scheduler sharing one pipelined divider among NUM_CH requesters,
// with a tag pipe that pairs each quotient with its channel and checks alignment.
module output_div_scheduler
  import output_pipe_pkg::*;
#(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned DIV_LATENCY = 10
) (
  input logic                   clock,
  input logic                   reset,
  output_div_scheduler_if.master bus
);

  localparam int unsigned CntW = $clog2(DIV_LATENCY + 2);

  localparam logic StFlush = 1'b0;
  localparam logic StRun   = 1'b1;

  logic                      state_q;
  logic [CntW-1:0]           flush_cnt_q;
  logic [CHAN_W-1:0]         rr_ptr_q;
  logic [CHAN_W-1:0]         issue_chan_q;
  logic [CHAN_W-1:0]         grant_idx;
  logic                      grant_found;
  logic                      run;
  logic                      issue;
  int unsigned               scan_idx;
  logic [NUM_CH-1:0]         req_shift;
  logic [NUM_CH*DIVIDEND_W-1:0] data_shift;
  logic [NUM_CH*DIVISOR_W-1:0]  divisor_shift;
  div_tag_t                  tag_in;
  div_tag_t                  tag_out;

  assign run       = (state_q == StRun);
  assign bus.ready = run;

  // First requester at or after rr_ptr_q, wrapping to channel 0.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    scan_idx    = 0;
    req_shift   = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      scan_idx = 32'(rr_ptr_q) + k;
      if (scan_idx >= NUM_CH) scan_idx = scan_idx - NUM_CH;
      req_shift = bus.req >> scan_idx;
      if (!grant_found && req_shift[0]) begin
        grant_found = 1'b1;
        grant_idx   = CHAN_W'(scan_idx);
      end
    end
  end

  assign issue         = run && grant_found;
  assign bus.ack       = issue ? (NUM_CH'(1) << grant_idx) : '0;
  assign data_shift    = bus.req_data >> (32'(grant_idx) * DIVIDEND_W);
  assign divisor_shift = bus.req_divisor >> (32'(grant_idx) * DIVISOR_W);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= StFlush;
      flush_cnt_q <= CntW'(DIV_LATENCY + 1);
    end else if (state_q == StFlush) begin
      flush_cnt_q <= flush_cnt_q - CntW'(1);
      if (flush_cnt_q == CntW'(1)) state_q <= StRun;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bus.div_start    <= 1'b0;
      bus.div_dividend <= '0;
      bus.div_divisor  <= '0;
      issue_chan_q     <= '0;
      rr_ptr_q         <= '0;
    end else begin
      bus.div_start <= issue;
      if (issue) begin
        bus.div_dividend <= data_shift[DIVIDEND_W-1:0];
        bus.div_divisor  <= divisor_shift[DIVISOR_W-1:0];
        issue_chan_q     <= grant_idx;
        rr_ptr_q         <= (grant_idx == CHAN_W'(NUM_CH - 1)) ? '0 : grant_idx + 1'b1;
      end
    end
  end

  // Zero divisors are still issued so the divider and tag pipe stay in step.
  assign tag_in = '{valid: bus.div_start, chan: issue_chan_q, z: (bus.div_divisor == '0)};

  div_tag_pipe #(
    .Depth(DIV_LATENCY)
  ) u_tag_pipe (
    .clock  (clock),
    .reset  (reset),
    .tag_in (tag_in),
    .tag_out(tag_out)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bus.res_valid <= 1'b0;
      bus.res_chan  <= '0;
      bus.res_data  <= '0;
      bus.err       <= 1'b0;
    end else begin
      bus.res_valid <= tag_out.valid;
      if (tag_out.valid) begin
        bus.res_chan <= tag_out.chan;
        bus.res_data <= tag_out.z ? DIV0_RESULT : bus.div_q;
      end
      if (run && (bus.div_startout != tag_out.valid)) bus.err <= 1'b1;
    end
  end

endmodule
